// File: rtl/text_buf_ctrl_if.sv
// Request channel between a message requester and text_buf_ctrl.
// Handshake: the requester raises req with msg_id and holds both until it sees
// ack, a one-cycle pulse on which msg_id is captured. busy covers the update
// and falls together with the one-cycle done pulse.
interface text_buf_ctrl_if;
  logic       req;
  logic [3:0] msg_id;
  logic       ack;
  logic       busy;
  logic       done;

  modport master (output req, output msg_id, input ack, input busy, input done);
  modport slave  (input req, input msg_id, output ack, output busy, output done);
endinterface

// File: rtl/text_buf_ctrl.sv
// Text-overlay sequencer: blanks the character buffer, copies one ROM message
// into it and re-enables the drawing stage on the next vertical-blank rise.
module text_buf_ctrl #(
  parameter int         COLS       = 25,
  parameter int         ROWS       = 7,
  parameter int         MSG_LEN    = 64,
  parameter int         BLANK_ID   = 15,
  parameter logic [6:0] SPACE_CODE = 7'h20
) (
  input  logic             clk,
  input  logic             rst,
  text_buf_ctrl_if.slave   ctrl,
  input  logic             vblnk_in,
  output logic [9:0]       msg_rom_addr,
  input  logic [7:0]       msg_rom_data,
  output logic             buf_we,
  output logic [9:0]       buf_addr,
  output logic [6:0]       buf_data,
  output logic             text_enable,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLEAR    = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] PROC     = 3'd3;
  localparam logic [2:0] WAIT_VBL = 3'd4;

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] ROW_END  = 5'(ROWS);
  localparam logic [5:0] LAST_IDX = 6'(MSG_LEN - 1);
  localparam logic [3:0] BLANK    = 4'(BLANK_ID);

  logic [2:0] state;
  logic [3:0] id;
  logic [4:0] row, col;
  logic [4:0] row_n, col_n;
  logic [5:0] idx;
  logic       blank, vblnk_d, busy_q, done_q, te_q;
  logic       is_term, is_nl, vbl_rise;

  assign is_term  = (msg_rom_data == 8'h00);
  assign is_nl    = (msg_rom_data == 8'h0A);
  assign vbl_rise = vblnk_in & ~vblnk_d;

  // ack is combinational so msg_id is captured in the same cycle it is acknowledged
  assign ctrl.ack     = (state == IDLE) & ctrl.req & ~rst;
  assign ctrl.busy    = busy_q;
  assign ctrl.done    = done_q;
  assign text_enable  = te_q;
  assign state_dbg    = state;
  assign msg_rom_addr = {id, idx};
  assign buf_addr     = {row, col};
  assign buf_we       = (state == CLEAR) | ((state == PROC) & ~is_term & ~is_nl);

  always_comb begin
    buf_data = 7'd0;
    if (state == CLEAR)     buf_data = SPACE_CODE;
    else if (state == PROC) buf_data = msg_rom_data[6:0];
  end

  // cursor position after consuming the current (non-terminator) character
  always_comb begin
    row_n = row;
    col_n = col;
    if (is_nl) begin
      row_n = row + 5'd1;
      col_n = 5'd0;
    end else if (col == LAST_COL) begin
      row_n = row + 5'd1;
      col_n = 5'd0;
    end else begin
      col_n = col + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      id      <= 4'd0;
      row     <= 5'd0;
      col     <= 5'd0;
      idx     <= 6'd0;
      blank   <= 1'b0;
      vblnk_d <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      vblnk_d <= vblnk_in;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl.ack) begin
            id     <= ctrl.msg_id;
            busy_q <= 1'b1;
            te_q   <= 1'b0;
            row    <= 5'd0;
            col    <= 5'd0;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          if (col == LAST_COL) begin
            col <= 5'd0;
            if (row == LAST_ROW) begin
              row <= 5'd0;
              idx <= 6'd0;
              if (id == BLANK) begin
                blank <= 1'b1;
                state <= WAIT_VBL;
              end else begin
                blank <= 1'b0;
                state <= FETCH;
              end
            end else begin
              row <= row + 5'd1;
            end
          end else begin
            col <= col + 5'd1;
          end
        end
        FETCH: state <= PROC;
        PROC: begin
          if (is_term) begin
            state <= WAIT_VBL;
          end else begin
            row <= row_n;
            col <= col_n;
            // running off the bottom of the box drops the rest of the message
            if (row_n == ROW_END || idx == LAST_IDX) begin
              state <= WAIT_VBL;
            end else begin
              idx   <= idx + 6'd1;
              state <= FETCH;
            end
          end
        end
        WAIT_VBL: begin
          if (vbl_rise) begin
            te_q   <= ~blank;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Directed bench for text_buf_ctrl: ROM model, write scoreboard, vblank driver.
module tb_text_buf_ctrl;

  localparam int ST_IDLE  = 0;
  localparam int ST_CLEAR = 1;
  localparam int ST_FETCH = 2;
  localparam int ST_WAIT  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_buf_ctrl_if ctrl();
  logic       vblnk_in;
  logic [9:0] msg_rom_addr;
  logic [7:0] msg_rom_data;
  logic       buf_we;
  logic [9:0] buf_addr;
  logic [6:0] buf_data;
  logic       text_enable;
  logic [2:0] state_dbg;

  text_buf_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl         (ctrl),
    .vblnk_in     (vblnk_in),
    .msg_rom_addr (msg_rom_addr),
    .msg_rom_data (msg_rom_data),
    .buf_we       (buf_we),
    .buf_addr     (buf_addr),
    .buf_data     (buf_data),
    .text_enable  (text_enable),
    .state_dbg    (state_dbg)
  );

  // synchronous message ROM
  logic [7:0] rom [0:1023];
  always @(posedge clk) msg_rom_data <= rom[msg_rom_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected buffer writes as {row, col, data}
  logic [16:0] exp_q[$];
  logic [16:0] exp_w;
  int          ack_cnt, busy_ack_cnt, fetch_cnt;
  logic [9:0]  last_fetch;

  always @(negedge clk) begin
    #1;
    if (ctrl.ack === 1'b1) begin
      ack_cnt++;
      if (ctrl.busy === 1'b1) busy_ack_cnt++;
    end
    if (32'(state_dbg) == ST_FETCH) begin
      fetch_cnt++;
      last_fetch = msg_rom_addr;
    end
    if (buf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_extra", 32'(buf_we), 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr", {15'd0, buf_addr, buf_data}, {15'd0, exp_w});
      end
    end
  end

  // driver tasks
  task automatic push_wr(input int r, input int c, input logic [7:0] d);
    exp_q.push_back({5'(r), 5'(c), d[6:0]});
  endtask

  task automatic push_clear();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 25; c++)
        push_wr(r, c, 8'h20);
  endtask

  task automatic send(input logic [3:0] id, input bit hold);
    @(negedge clk);
    ctrl.msg_id  = id;
    ctrl.req     = 1'b1;
    ack_cnt      = 0;
    busy_ack_cnt = 0;
    fetch_cnt    = 0;
    #2;
    check("ack_hi", 32'(ctrl.ack), 32'd1);
    @(negedge clk);
    if (!hold) ctrl.req = 1'b0;
    #2;
    check("ack_pulse", 32'(ctrl.ack), 32'd0);
    check("busy_on", 32'(ctrl.busy), 32'd1);
    check("te_off", 32'(text_enable), 32'd0);
    check("st_clear", 32'(state_dbg), ST_CLEAR);
  endtask

  task automatic check_reset_vals();
    check("rst_ack", 32'(ctrl.ack), 32'd0);
    check("rst_busy", 32'(ctrl.busy), 32'd0);
    check("rst_done", 32'(ctrl.done), 32'd0);
    check("rst_we", 32'(buf_we), 32'd0);
    check("rst_addr", 32'(buf_addr), 32'd0);
    check("rst_data", 32'(buf_data), 32'd0);
    check("rst_rom_addr", 32'(msg_rom_addr), 32'd0);
    check("rst_te", 32'(text_enable), 32'd0);
    check("rst_state", 32'(state_dbg), ST_IDLE);
  endtask

  // waits for WAIT_VBL, then produces a vblank rise and checks the done pulse
  task automatic finish_vbl(input bit blank, input bit pre_high, input int left);
    int n = 0;
    while (32'(state_dbg) != ST_WAIT && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_wait", 32'(state_dbg), ST_WAIT);
    check("wr_count", 32'(exp_q.size()), 32'(left));
    if (pre_high) begin
      repeat (3) begin
        @(negedge clk);
        #2;
        check("no_done_in_vbl", 32'(ctrl.done), 32'd0);
      end
      @(negedge clk);
      vblnk_in = 1'b0;
    end
    repeat (2) @(negedge clk);
    #2;
    check("done_wait", 32'(ctrl.done), 32'd0);
    check("te_wait", 32'(text_enable), 32'd0);
    check("busy_wait", 32'(ctrl.busy), 32'd1);
    @(negedge clk);
    vblnk_in = 1'b1;
    @(negedge clk);
    #2;
    check("done_pulse", 32'(ctrl.done), 32'd1);
    check("busy_off", 32'(ctrl.busy), 32'd0);
    check("te_final", 32'(text_enable), 32'(!blank));
    check("st_idle", 32'(state_dbg), ST_IDLE);
    @(negedge clk);
    vblnk_in = 1'b0;
    #2;
    check("done_one_cycle", 32'(ctrl.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    ctrl.req    = 1'b0;
    ctrl.msg_id = 4'd0;
    vblnk_in    = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    // slot 2: "HI"
    rom[128] = 8'h48; rom[129] = 8'h49;
    // slot 3: "A" NL "B"
    rom[192] = 8'h41; rom[193] = 8'h0A; rom[194] = 8'h42;
    // slot 5: 30 x 'X' then terminator
    for (int i = 0; i < 30; i++) rom[320 + i] = 8'h58;
    // slot 6: full 64-character slot, no terminator
    for (int i = 0; i < 64; i++) rom[384 + i] = 8'(8'h41 + (i % 26));
    // slot 7: "Z" then seven newlines then "Q" (falls off the box)
    rom[448] = 8'h5A;
    for (int i = 1; i <= 7; i++) rom[448 + i] = 8'h0A;
    rom[456] = 8'h51;

    repeat (3) @(negedge clk);
    #2;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // "HI"
    push_clear();
    push_wr(0, 0, 8'h48);
    push_wr(0, 1, 8'h49);
    send(4'd2, 1'b0);
    finish_vbl(1'b0, 1'b0, 0);
    check("hi_fetches", 32'(fetch_cnt), 32'd3);
    check("hi_acks", 32'(ack_cnt), 32'd1);

    // column wrap at 25
    push_clear();
    for (int i = 0; i < 30; i++) push_wr(i / 25, i % 25, 8'h58);
    send(4'd5, 1'b0);
    finish_vbl(1'b0, 1'b0, 0);
    check("wrap_fetches", 32'(fetch_cnt), 32'd31);

    // MSG_LEN limit, entering WAIT_VBL while vblank is already high
    push_clear();
    for (int i = 0; i < 64; i++) push_wr(i / 25, i % 25, rom[384 + i]);
    send(4'd6, 1'b0);
    vblnk_in = 1'b1;
    finish_vbl(1'b0, 1'b1, 0);
    check("len_fetches", 32'(fetch_cnt), 32'd64);
    check("len_last_addr", 32'(last_fetch), 32'd447);

    // row overflow drops the trailing character
    push_clear();
    push_wr(0, 0, 8'h5A);
    send(4'd7, 1'b0);
    finish_vbl(1'b0, 1'b0, 0);
    check("ovf_fetches", 32'(fetch_cnt), 32'd8);

    // newline, with req held through busy; msg_id changes to BLANK_ID meanwhile
    push_clear();
    push_wr(0, 0, 8'h41);
    push_wr(1, 0, 8'h42);
    push_clear();
    send(4'd3, 1'b1);
    @(negedge clk);
    ctrl.msg_id = 4'd15;
    finish_vbl(1'b0, 1'b0, 175);
    check("held_no_reack", 32'(busy_ack_cnt), 32'd0);
    check("held_acks", 32'(ack_cnt), 32'd2);
    check("nl_fetches", 32'(fetch_cnt), 32'd4);
    check("blank_te_fall", 32'(text_enable), 32'd0);
    check("blank_busy", 32'(ctrl.busy), 32'd1);
    check("blank_state", 32'(state_dbg), ST_CLEAR);
    fetch_cnt = 0;
    @(negedge clk);
    ctrl.req = 1'b0;
    finish_vbl(1'b1, 1'b0, 0);
    check("blank_fetches", 32'(fetch_cnt), 32'd0);

    // reset in the middle of CLEAR
    push_clear();
    send(4'd2, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check_reset_vals();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // recovery after reset
    push_clear();
    push_wr(0, 0, 8'h48);
    push_wr(0, 1, 8'h49);
    send(4'd2, 1'b0);
    finish_vbl(1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
